// File: rtl/rfile_sb_pkg.sv
// Shared constants and helpers for the rfile_sb register file and its scoreboard.
package rfile_sb_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;

    // Architectural zero register: never stored, never busy.
    localparam int ZERO_REG  = 0;

    // Bit offset of port k inside a packed multi-port bus of w-bit fields.
    function automatic int unsigned port_off(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/rfile_sb_score.sv
// Write-pending scoreboard: one busy bit per register plus a running count of busy bits.
// Allocation beats a same-edge writeback to the same register.
module rfile_sb_score
    import rfile_sb_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addrd_i,
    input  logic             alloc_i,
    input  logic [AW-1:0]    alloc_addr_i,
    output logic [NREGS-1:0] busy_o,
    output logic [AW-1:0]    pend_cnt_o
);

    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_d;
    logic [AW-1:0]    pend_cnt_q;
    logic [AW-1:0]    pend_cnt_d;
    logic             alloc_ok;
    logic             wb_ok;
    logic             set_eff;
    logic             clr_eff;

    assign busy_o     = {busy_q, 1'b0};
    assign pend_cnt_o = pend_cnt_q;

    assign alloc_ok = alloc_i && (alloc_addr_i != AW'(ZERO_REG));
    assign wb_ok    = we_i && (addrd_i != AW'(ZERO_REG));

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_busy
            always_comb begin
                busy_d[gi] = busy_q[gi];
                if (alloc_ok && (alloc_addr_i == AW'(gi)))
                    busy_d[gi] = 1'b1;
                else if (wb_ok && (addrd_i == AW'(gi)))
                    busy_d[gi] = 1'b0;
            end
        end
    endgenerate

    // Count only transitions that actually flip a bit, so the counter tracks popcount(busy).
    assign set_eff = alloc_ok && !busy_o[alloc_addr_i];
    assign clr_eff = wb_ok && busy_o[addrd_i] && !(alloc_ok && (alloc_addr_i == addrd_i));

    always_comb begin
        pend_cnt_d = pend_cnt_q;
        case ({set_eff, clr_eff})
            2'b10:   pend_cnt_d = pend_cnt_q + AW'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - AW'(1);
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

endmodule

// File: rtl/rfile_sb.sv
// Parametrised multi-port register file with write-pending scoreboard; x0 hardwired to zero.
// Define RFILE_SB_BYPASS_EN to forward same-cycle writeback data/readiness to the read ports.
module rfile_sb
    import rfile_sb_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addrd_i,
    input  logic [DW-1:0]     datard_i,
    input  logic              alloc_i,
    input  logic [AW-1:0]     alloc_addr_i,
    input  logic [NRD*AW-1:0] addrs_i,
    output logic [NRD*DW-1:0] datars_o,
    output logic [NRD-1:0]    ready_o,
    output logic [NREGS-1:0]  busy_o,
    output logic [AW-1:0]     pend_cnt_o
);

    logic [DW-1:0] mem_q [NREGS-1:1];
    logic          wr_ok;

    assign wr_ok = we_i && (addrd_i != AW'(ZERO_REG));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 1; i < NREGS; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[addrd_i] <= datard_i;
        end
    end

    rfile_sb_score #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_score (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .we_i         (we_i),
        .addrd_i      (addrd_i),
        .alloc_i      (alloc_i),
        .alloc_addr_i (alloc_addr_i),
        .busy_o       (busy_o),
        .pend_cnt_o   (pend_cnt_o)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] rd_addr;
            logic [DW-1:0] stored;

            assign rd_addr = addrs_i[port_off(gi, AW) +: AW];

            always_comb begin
                stored = '0;
                if (rd_addr != AW'(ZERO_REG))
                    stored = mem_q[rd_addr];
            end

`ifdef RFILE_SB_BYPASS_EN
            logic hit;
            assign hit = wr_ok && (addrd_i == rd_addr);

            always_comb begin
                datars_o[port_off(gi, DW) +: DW] = stored;
                ready_o[gi] = !busy_o[rd_addr];
                if (hit) begin
                    datars_o[port_off(gi, DW) +: DW] = datard_i;
                    // A same-cycle allocation of this register hands it to a newer producer.
                    ready_o[gi] = !(alloc_i && (alloc_addr_i == addrd_i));
                end
            end
`else
            assign datars_o[port_off(gi, DW) +: DW] = stored;
            assign ready_o[gi] = !busy_o[rd_addr];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_rfile_sb.sv
// Directed self-checking bench for rfile_sb (default parameters, either bypass build).
module tb_rfile_sb;

    localparam int DW = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int AW = 5;

`ifdef RFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_i;
    logic              we_i;
    logic [AW-1:0]     addrd_i;
    logic [DW-1:0]     datard_i;
    logic              alloc_i;
    logic [AW-1:0]     alloc_addr_i;
    logic [NRD*AW-1:0] addrs_i;
    logic [NRD*DW-1:0] datars_o;
    logic [NRD-1:0]    ready_o;
    logic [NREGS-1:0]  busy_o;
    logic [AW-1:0]     pend_cnt_o;

    int checks = 0;
    int errors = 0;

    rfile_sb #(.DW(DW), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .we_i         (we_i),
        .addrd_i      (addrd_i),
        .datard_i     (datard_i),
        .alloc_i      (alloc_i),
        .alloc_addr_i (alloc_addr_i),
        .addrs_i      (addrs_i),
        .datars_o     (datars_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .pend_cnt_o   (pend_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_i = 1'b0; alloc_i = 1'b0; rst_i = 1'b0;
        addrd_i = '0; datard_i = '0; alloc_addr_i = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        addrs_i = {a1, a0};
        #1;
    endtask

    task automatic check_all_clear(input string tag);
        for (int a = 0; a < NREGS; a++) begin
            set_rd(AW'(a), AW'(NREGS - 1 - a));
            checks++;
            if (datars_o !== '0 || ready_o !== 2'b11) begin
                errors++;
                $display("FAIL %s addr %0d: data=%h ready=%b required data=0 ready=11", tag, a, datars_o, ready_o);
            end
        end
        checks++;
        if (busy_o !== '0 || pend_cnt_o !== '0) begin
            errors++;
            $display("FAIL %s_sb: busy=%h pend=%0d required busy=0 pend=0", tag, busy_o, pend_cnt_o);
        end
        $display("txn %s: all addresses zero/ready checked", tag);
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        check_all_clear("reset");
    endtask

    task automatic test_write();
        we_i = 1'b1; addrd_i = 5'd5; datard_i = 32'hAAAAAAAA;
        set_rd(5'd5, 5'd0);
        checks++;
        if (datars_o[31:0] !== (BYP ? 32'hAAAAAAAA : 32'h0)) begin
            errors++;
            $display("FAIL wr_same_cycle: got %h required %h", datars_o[31:0], BYP ? 32'hAAAAAAAA : 32'h0);
        end
        step();
        idle();
        set_rd(5'd5, 5'd5);
        checks++;
        if (datars_o !== {2{32'hAAAAAAAA}} || ready_o !== 2'b11 || pend_cnt_o !== 5'd0) begin
            errors++;
            $display("FAIL wr_next_cycle: data=%h ready=%b pend=%0d required aaaaaaaa x2 ready=11 pend=0", datars_o, ready_o, pend_cnt_o);
        end
        $display("txn write x5 = aaaaaaaa");
    endtask

    task automatic test_x0();
        we_i = 1'b1; addrd_i = 5'd0; datard_i = 32'hFFFFFFFF;
        alloc_i = 1'b1; alloc_addr_i = 5'd0;
        set_rd(5'd0, 5'd0);
        checks++;
        if (datars_o !== '0 || ready_o !== 2'b11) begin
            errors++;
            $display("FAIL x0_same_cycle: data=%h ready=%b required 0 / 11", datars_o, ready_o);
        end
        step();
        idle();
        set_rd(5'd0, 5'd5);
        checks++;
        if (datars_o[31:0] !== 32'h0 || busy_o[0] !== 1'b0 || pend_cnt_o !== 5'd0 || datars_o[63:32] !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL x0: data=%h busy0=%b pend=%0d required x0=0 x5=aaaaaaaa busy0=0 pend=0", datars_o, busy_o[0], pend_cnt_o);
        end
        $display("txn write+alloc x0 ignored");
    endtask

    task automatic test_alloc_pair();
        alloc_i = 1'b1; alloc_addr_i = 5'd6;
        step();
        alloc_addr_i = 5'd7;
        step();
        idle();
        set_rd(5'd6, 5'd7);
        checks++;
        if (pend_cnt_o !== 5'd2 || ready_o !== 2'b00 || busy_o !== 32'h000000C0) begin
            errors++;
            $display("FAIL alloc_pair: pend=%0d ready=%b busy=%h required 2 / 00 / 000000c0", pend_cnt_o, ready_o, busy_o);
        end
        we_i = 1'b1; addrd_i = 5'd6; datard_i = 32'h12345678;
        #1;
        checks++;
        if (ready_o !== {1'b0, BYP} || datars_o[31:0] !== (BYP ? 32'h12345678 : 32'h0)) begin
            errors++;
            $display("FAIL wb6_same_cycle: ready=%b data=%h required ready=%b", ready_o, datars_o[31:0], {1'b0, BYP});
        end
        step();
        idle();
        #1;
        checks++;
        if (pend_cnt_o !== 5'd1 || ready_o !== 2'b01 || datars_o[31:0] !== 32'h12345678 || busy_o !== 32'h00000080) begin
            errors++;
            $display("FAIL wb6: pend=%0d ready=%b data=%h busy=%h required 1 / 01 / 12345678 / 00000080", pend_cnt_o, ready_o, datars_o[31:0], busy_o);
        end
        $display("txn alloc x6,x7 then writeback x6");
    endtask

    task automatic test_alloc_wb_same();
        alloc_i = 1'b1; alloc_addr_i = 5'd8;
        step();
        idle();
        set_rd(5'd8, 5'd7);
        checks++;
        if (pend_cnt_o !== 5'd2 || busy_o[8] !== 1'b1) begin
            errors++;
            $display("FAIL alloc8: pend=%0d busy8=%b required 2 / 1", pend_cnt_o, busy_o[8]);
        end
        alloc_i = 1'b1; alloc_addr_i = 5'd8;
        we_i = 1'b1; addrd_i = 5'd8; datard_i = 32'h0BADF00D;
        #1;
        checks++;
        if (ready_o[0] !== 1'b0 || datars_o[31:0] !== (BYP ? 32'h0BADF00D : 32'h0)) begin
            errors++;
            $display("FAIL alloc_wb8_same_cycle: ready0=%b data=%h required ready0=0", ready_o[0], datars_o[31:0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (busy_o[8] !== 1'b1 || datars_o[31:0] !== 32'h0BADF00D || pend_cnt_o !== 5'd2 || ready_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL alloc_wb8: busy8=%b data=%h pend=%0d ready0=%b required 1 / 0badf00d / 2 / 0", busy_o[8], datars_o[31:0], pend_cnt_o, ready_o[0]);
        end
        $display("txn alloc+writeback x8 same edge");
    endtask

    task automatic test_reset_mid();
        alloc_i = 1'b1; alloc_addr_i = 5'd9;
        step();
        idle();
        we_i = 1'b1; addrd_i = 5'd10; datard_i = 32'h00000055;
        step();
        idle();
        set_rd(5'd10, 5'd9);
        checks++;
        if (datars_o[31:0] !== 32'h00000055 || ready_o !== 2'b01 || pend_cnt_o !== 5'd3) begin
            errors++;
            $display("FAIL pre_reset: data=%h ready=%b pend=%0d required 00000055 / 01 / 3", datars_o[31:0], ready_o, pend_cnt_o);
        end
        rst_i = 1'b1; alloc_i = 1'b1; alloc_addr_i = 5'd11;
        we_i = 1'b1; addrd_i = 5'd12; datard_i = 32'hDEADBEEF;
        step();
        idle();
        check_all_clear("reset_mid");
    endtask

    initial begin
        idle();
        addrs_i = '0;
        test_reset();
        test_write();
        test_x0();
        test_alloc_pair();
        test_alloc_wb_same();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rfile_sb.md
# rfile_sb

Parametrised multi-port register file with an integrated write-pending scoreboard for the pipelined core. It replaces the fixed 32×32, two-read-port file: data width, register count and read-port count are parameters; register 0 is hardwired to zero. A per-register busy bit is set when an instruction that writes that register issues and cleared on writeback, so decode can detect RAW hazards. Sits between decode/issue (reads, allocation) and writeback (write port).

## Interface
- DW, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥ 2
- NRD, 2, number of read ports, ≥ 1
- AW (localparam), $clog2(NREGS), register address width

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- we_i  in  1  writeback enable
- addrd_i  in  AW  writeback register address
- datard_i  in  DW  writeback data
- alloc_i  in  1  issue-time allocation: mark alloc_addr_i busy
- alloc_addr_i  in  AW  register being allocated
- addrs_i  in  NRD*AW  read addresses; port k at bits [k*AW +: AW]
- datars_o  out  NRD*DW  read data; port k at bits [k*DW +: DW]
- ready_o  out  NRD  port k's register has no pending write
- busy_o  out  NREGS  raw busy vector; bit 0 always 0
- pend_cnt_o  out  AW  number of busy registers (at most NREGS-1)

## Operation
- Storage: NREGS-1 registers of DW bits. Index 0 is not stored; it reads as 0 and is never busy.
- Write: on a rising edge with we_i=1 and addrd_i≠0, the register takes datard_i. Writes to 0 are discarded.
- Read: each port is combinational. datars_o[k] = reg[addrs_i[k]]; ready_o[k] = !busy[addrs_i[k]]. Any number of ports may read the same address.
- Scoreboard update for register r≠0 on each edge:
  - alloc_i=1 and alloc_addr_i=r: busy[r] becomes 1. Allocation wins over a simultaneous writeback to r, because a newer producer now owns r.
  - Otherwise, we_i=1 and addrd_i=r: busy[r] becomes 0.
  - Otherwise: busy[r] is held.
- Allocation of register 0 is ignored.
- Writeback to a non-busy register writes the data and leaves busy at 0.
- Re-allocating a register that is already busy leaves it busy; there is no nesting count.
- pend_cnt_o is a registered counter updated each edge by (+1 if a set takes effect on a non-busy register) and (−1 if a clear takes effect on a busy register). Net 0 when both happen. It must always equal popcount(busy).

## Timing
- Reset (rst_i=1 at an edge) overrides we_i and alloc_i. All registers become 0, busy becomes all-zero, pend_cnt_o becomes 0.
- Outputs after reset, with any address: datars_o all 0, ready_o all 1, busy_o 0.
- Read latency: 0 cycles (combinational from addrs_i).
- Write latency: data is visible on the read ports in the cycle after the write edge, unless the macro is enabled (see Configuration).
- ready_o / busy_o:
  - Allocation at edge N makes ready_o=0 from cycle N+1.
  - Writeback at edge M makes ready_o=1 from cycle M+1, or in the same cycle when bypass is enabled.
- Reset asserted mid-operation discards pending writes and allocations. Nothing from before reset survives.

## Configuration
- RFILE_SB_BYPASS_EN defined:
  - Each read port forwards in the writeback cycle: if we_i=1, addrd_i≠0 and addrd_i==addrs_i[k], then datars_o[k]=datard_i.
  - In the same case, ready_o[k]=1 unless alloc_i=1 with alloc_addr_i==addrd_i in that cycle.
  - The read path becomes combinational from the write inputs.
- Undefined: reads return stored state only. Writeback effects appear one cycle later.

## Structure
- Shared package holds:
  - default DW/NREGS/NRD constants;
  - the zero-register index constant;
  - a function for the packed-port slice offset.
- One sub-module, rfile_sb_score: busy vector plus pend_cnt counter, with its alloc/writeback priority logic. The data array and read muxes stay in the top module.

## Test plan
- Reset then read all addresses on all ports → datars_o=0, ready_o all 1, pend_cnt_o=0.
- Write 0xAAAAAAAA to x5, read x5 on port 0 in the same cycle → old value 0 without bypass, 0xAAAAAAAA with RFILE_SB_BYPASS_EN; next cycle 0xAAAAAAAA in both builds.
- Write 0xFFFFFFFF to x0 and allocate x0 → x0 reads 0, busy_o[0]=0, pend_cnt_o unchanged.
- Allocate x6 and x7 on consecutive cycles → pend_cnt_o=2, ready_o=0 for both; writeback x6 → pend_cnt_o=1, x6 ready.
- Same edge: alloc x8 and writeback x8 while x8 is busy → busy_o[8] stays 1, data updated, pend_cnt_o unchanged.
- Allocate x9, write x10, then assert rst_i in the same cycle as another alloc → all zero, ready_o all 1, pend_cnt_o=0.
